// File: rtl/multicycle_ctrl_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multicycle_ctrl_param                                                      |
// | Multicycle MIPS-subset control unit with parametrised memory wait states   |
// | and a precise exception path (EPC capture, cause register, vector jump).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module multicycle_ctrl_param #(
    parameter int MEM_WAIT = 2,
    parameter int CNT_W    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] OpCode,
    input  logic [5:0] Funct,
    input  logic       O,
    input  logic       Zero,
    output logic [2:0] IorD,
    output logic       MemWR,
    output logic       IRWrite,
    output logic       MDRWrite,
    output logic [1:0] RegDst,
    output logic       RegWR,
    output logic       WriteA,
    output logic       WriteB,
    output logic [1:0] AluSrcA,
    output logic [2:0] AluSrcB,
    output logic [2:0] AluOperation,
    output logic       AluOutWrite,
    output logic [2:0] MemToReg,
    output logic [2:0] PCSource,
    output logic       PCWrite,
    output logic       EPCWrite,
    output logic [1:0] exc_cause,
    output logic [5:0] state_o
);

    typedef enum logic [5:0] {
        S_RST       = 6'd0,
        S_FETCH     = 6'd1,
        S_DECODE    = 6'd2,
        S_R_EXEC    = 6'd3,
        S_R_WB      = 6'd4,
        S_ADDI_EXEC = 6'd5,
        S_ADDI_WB   = 6'd6,
        S_MEM_ADDR  = 6'd7,
        S_LW_MEM    = 6'd8,
        S_LW_WB     = 6'd9,
        S_SW_MEM    = 6'd10,
        S_BRANCH    = 6'd11,
        S_JUMP      = 6'd12,
        S_JR        = 6'd13,
        S_EXC       = 6'd14
    } state_t;

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(MEM_WAIT);
    localparam logic [CNT_W-1:0] C_ONE  = CNT_W'(1);
    localparam logic [2:0]       C_ADD  = 3'b001;
    localparam logic [2:0]       C_SUB  = 3'b010;
    localparam logic [2:0]       C_AND  = 3'b011;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       cause_q, cause_d;

    logic       r_funct_ok;
    logic [2:0] funct_op;
    logic       r_ovf;

    // IR is stable from DECODE onwards, so Funct can steer both exec and writeback.
    always_comb begin
        r_funct_ok = (Funct == 6'h20) || (Funct == 6'h22) || (Funct == 6'h24);
        case (Funct)
            6'h22:   funct_op = C_SUB;
            6'h24:   funct_op = C_AND;
            default: funct_op = C_ADD;
        endcase
        r_ovf = O && (Funct != 6'h24);
    end

    always_comb begin
        IorD         = 3'b000;
        MemWR        = 1'b0;
        IRWrite      = 1'b0;
        MDRWrite     = 1'b0;
        RegDst       = 2'b00;
        RegWR        = 1'b0;
        WriteA       = 1'b0;
        WriteB       = 1'b0;
        AluSrcA      = 2'b00;
        AluSrcB      = 3'b000;
        AluOperation = 3'b000;
        AluOutWrite  = 1'b0;
        MemToReg     = 3'b000;
        PCSource     = 3'b000;
        PCWrite      = 1'b0;
        EPCWrite     = 1'b0;
        state_d      = state_q;
        cause_d      = cause_q;

        case (state_q)
            S_RST: state_d = S_FETCH;
            S_FETCH: begin
                AluSrcB      = 3'b001;
                AluOperation = C_ADD;
                if (cnt_q == C_LAST) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                WriteA       = 1'b1;
                WriteB       = 1'b1;
                AluSrcB      = 3'b011;
                AluOperation = C_ADD;
                AluOutWrite  = 1'b1;
                case (OpCode)
                    6'h00: begin
                        if (r_funct_ok) begin
                            state_d = S_R_EXEC;
                        end else if (Funct == 6'h08) begin
                            state_d = S_JR;
                        end else begin
                            state_d = S_EXC;
                            cause_d = 2'b01;
                        end
                    end
                    6'h08:        state_d = S_ADDI_EXEC;
                    6'h23, 6'h2B: state_d = S_MEM_ADDR;
                    6'h04, 6'h05: state_d = S_BRANCH;
                    6'h02:        state_d = S_JUMP;
                    default: begin
                        state_d = S_EXC;
                        cause_d = 2'b01;
                    end
                endcase
            end
            S_R_EXEC, S_R_WB: begin
                AluSrcA      = 2'b01;
                AluOperation = funct_op;
                if (state_q == S_R_EXEC) begin
                    AluOutWrite = 1'b1;
                    state_d     = S_R_WB;
                end else if (r_ovf) begin
                    state_d = S_EXC;
                    cause_d = 2'b10;
                end else begin
                    RegDst  = 2'b01;
                    RegWR   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_ADDI_EXEC, S_ADDI_WB, S_MEM_ADDR: begin
                AluSrcA      = 2'b01;
                AluSrcB      = 3'b010;
                AluOperation = C_ADD;
                if (state_q == S_ADDI_EXEC) begin
                    AluOutWrite = 1'b1;
                    state_d     = S_ADDI_WB;
                end else if (state_q == S_MEM_ADDR) begin
                    AluOutWrite = 1'b1;
                    state_d     = (OpCode == 6'h23) ? S_LW_MEM : S_SW_MEM;
                end else if (O) begin
                    state_d = S_EXC;
                    cause_d = 2'b10;
                end else begin
                    RegWR   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_LW_MEM: begin
                IorD = 3'b001;
                if (cnt_q == C_LAST) begin
                    MDRWrite = 1'b1;
                    state_d  = S_LW_WB;
                end
            end
            S_LW_WB: begin
                MemToReg = 3'b001;
                RegWR    = 1'b1;
                state_d  = S_FETCH;
            end
            S_SW_MEM: begin
                IorD    = 3'b001;
                MemWR   = 1'b1;
                state_d = S_FETCH;
            end
            S_BRANCH: begin
                AluSrcA      = 2'b01;
                AluOperation = C_SUB;
                PCSource     = 3'b001;
                PCWrite      = (OpCode == 6'h04) ? Zero : ~Zero;
                state_d      = S_FETCH;
            end
            S_JUMP: begin
                PCSource = 3'b010;
                PCWrite  = 1'b1;
                state_d  = S_FETCH;
            end
            S_JR: begin
                PCSource = 3'b011;
                PCWrite  = 1'b1;
                state_d  = S_FETCH;
            end
            S_EXC: begin
                // First cycle saves PC-4 (PC already advanced past the faulting word).
                if (cnt_q == '0) begin
                    AluSrcB      = 3'b001;
                    AluOperation = C_SUB;
                    EPCWrite     = 1'b1;
                end else begin
                    PCSource = 3'b100;
                    PCWrite  = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        cnt_d = (state_d != state_q) ? '0 : cnt_q + C_ONE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
            cnt_q   <= '0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    assign exc_cause = cause_q;
    assign state_o   = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_multicycle_ctrl_param                                                   |
// | Randomised + directed bench for two instances (MEM_WAIT=2 and MEM_WAIT=3). |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_multicycle_ctrl_param;

    typedef struct packed {
        logic [2:0] iord;
        logic       memwr;
        logic       irwrite;
        logic       mdrwrite;
        logic [1:0] regdst;
        logic       regwr;
        logic       writea;
        logic       writeb;
        logic [1:0] alusrca;
        logic [2:0] alusrcb;
        logic [2:0] aluop;
        logic       aluoutwrite;
        logic [2:0] memtoreg;
        logic [2:0] pcsource;
        logic       pcwrite;
        logic       epcwrite;
    } outs_t;

    localparam logic [2:0] C_ADD = 3'b001;
    localparam logic [2:0] C_SUB = 3'b010;
    localparam logic [2:0] C_AND = 3'b011;

    logic       clk;
    logic       rst_n   [2];
    logic [5:0] op_i    [2];
    logic [5:0] fn_i    [2];
    logic       o_i     [2];
    logic       z_i     [2];
    outs_t      got     [2];
    logic [1:0] cause_w [2];
    logic [5:0] st_w    [2];

    int n_cmp = 0;
    int n_bad = 0;

    outs_t      q_o[$];
    logic [1:0] q_c[$];
    logic [1:0] m_cause;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [2:0] iord, alusrcb, aluop, memtoreg, pcsource;
        logic [1:0] regdst, alusrca, cause;
        logic       memwr, irwrite, mdrwrite, regwr, writea, writeb;
        logic       aluoutwrite, pcwrite, epcwrite;
        logic [5:0] st;

        multicycle_ctrl_param #(.MEM_WAIT((k == 0) ? 2 : 3), .CNT_W(5)) u_dut (
            .clk(clk), .reset(rst_n[k]), .OpCode(op_i[k]), .Funct(fn_i[k]),
            .O(o_i[k]), .Zero(z_i[k]), .IorD(iord), .MemWR(memwr),
            .IRWrite(irwrite), .MDRWrite(mdrwrite), .RegDst(regdst), .RegWR(regwr),
            .WriteA(writea), .WriteB(writeb), .AluSrcA(alusrca), .AluSrcB(alusrcb),
            .AluOperation(aluop), .AluOutWrite(aluoutwrite), .MemToReg(memtoreg),
            .PCSource(pcsource), .PCWrite(pcwrite), .EPCWrite(epcwrite),
            .exc_cause(cause), .state_o(st)
        );

        assign got[k] = {iord, memwr, irwrite, mdrwrite, regdst, regwr, writea, writeb,
                         alusrca, alusrcb, aluop, aluoutwrite, memtoreg, pcsource,
                         pcwrite, epcwrite};
        assign cause_w[k] = cause;
        assign st_w[k]    = st;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void push(input outs_t v);
        q_o.push_back(v);
        q_c.push_back(m_cause);
    endfunction

    function automatic void push_exc(input logic [1:0] c);
        outs_t v;
        m_cause   = c;
        v         = '0;
        v.alusrcb = 3'b001;
        v.aluop   = C_SUB;
        v.epcwrite = 1'b1;
        push(v);
        v          = '0;
        v.pcsource = 3'b100;
        v.pcwrite  = 1'b1;
        push(v);
    endfunction

    // Expected per-cycle output words for one instruction, from FETCH to its last cycle.
    function automatic void build(input int mw, input logic [5:0] op, input logic [5:0] fn,
                                  input logic o, input logic z);
        outs_t      v;
        logic [2:0] alu;
        q_o.delete();
        q_c.delete();
        for (int i = 0; i <= mw; i++) begin
            v         = '0;
            v.alusrcb = 3'b001;
            v.aluop   = C_ADD;
            v.irwrite = (i == mw);
            v.pcwrite = (i == mw);
            push(v);
        end
        v = '0;
        v.writea = 1'b1; v.writeb = 1'b1; v.alusrcb = 3'b011; v.aluop = C_ADD;
        v.aluoutwrite = 1'b1;
        push(v);
        v = '0;
        if (op == 6'h00 && (fn == 6'h20 || fn == 6'h22 || fn == 6'h24)) begin
            alu = (fn == 6'h22) ? C_SUB : (fn == 6'h24) ? C_AND : C_ADD;
            v.alusrca = 2'b01; v.aluop = alu; v.aluoutwrite = 1'b1;
            push(v);
            v.aluoutwrite = 1'b0;
            if (o && alu != C_AND) begin
                push(v);
                push_exc(2'b10);
            end else begin
                v.regdst = 2'b01; v.regwr = 1'b1;
                push(v);
            end
        end else if (op == 6'h00 && fn == 6'h08) begin
            v.pcsource = 3'b011; v.pcwrite = 1'b1;
            push(v);
        end else if (op == 6'h08) begin
            v.alusrca = 2'b01; v.alusrcb = 3'b010; v.aluop = C_ADD; v.aluoutwrite = 1'b1;
            push(v);
            v.aluoutwrite = 1'b0;
            if (o) begin
                push(v);
                push_exc(2'b10);
            end else begin
                v.regwr = 1'b1;
                push(v);
            end
        end else if (op == 6'h23 || op == 6'h2B) begin
            v.alusrca = 2'b01; v.alusrcb = 3'b010; v.aluop = C_ADD; v.aluoutwrite = 1'b1;
            push(v);
            if (op == 6'h23) begin
                for (int i = 0; i <= mw; i++) begin
                    v = '0; v.iord = 3'b001; v.mdrwrite = (i == mw);
                    push(v);
                end
                v = '0; v.memtoreg = 3'b001; v.regwr = 1'b1;
                push(v);
            end else begin
                v = '0; v.iord = 3'b001; v.memwr = 1'b1;
                push(v);
            end
        end else if (op == 6'h04 || op == 6'h05) begin
            v.alusrca = 2'b01; v.aluop = C_SUB; v.pcsource = 3'b001;
            v.pcwrite = (op == 6'h04) ? z : ~z;
            push(v);
        end else if (op == 6'h02) begin
            v.pcsource = 3'b010; v.pcwrite = 1'b1;
            push(v);
        end else begin
            push_exc(2'b01);
        end
    endfunction

    // Entered and left at posedge+1; abort_at >= 0 pulls reset after that cycle's check.
    task automatic run(input int k, input logic [5:0] op, input logic [5:0] fn,
                       input logic o, input logic z, input int abort_at);
        op_i[k] = op; fn_i[k] = fn; o_i[k] = o; z_i[k] = z;
        build((k == 0) ? 2 : 3, op, fn, o, z);
        for (int i = 0; i < q_o.size(); i++) begin
            @(negedge clk);
            chk($sformatf("d%0d_op%h_fn%h_c%0d_out", k, op, fn, i), 32'(got[k]), 32'(q_o[i]));
            chk($sformatf("d%0d_op%h_fn%h_c%0d_cause", k, op, fn, i), 32'(cause_w[k]), 32'(q_c[i]));
            if (i == abort_at) begin
                do_reset(k);
                return;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int k);
        rst_n[k] = 1'b0;
        #1;
        chk($sformatf("d%0d_rst_out", k), 32'(got[k]), 32'h0);
        chk($sformatf("d%0d_rst_cause", k), 32'(cause_w[k]), 32'h0);
        chk($sformatf("d%0d_rst_state", k), 32'(st_w[k]), 32'h0);
        m_cause = 2'b00;
        @(negedge clk);
        rst_n[k] = 1'b1;
        chk($sformatf("d%0d_rstrel_out", k), 32'(got[k]), 32'h0);
        @(posedge clk);
        #1;
    endtask

    logic [5:0] op_tab [9] = '{6'h00, 6'h00, 6'h08, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h3F};
    logic [5:0] fn_tab [5] = '{6'h20, 6'h22, 6'h24, 6'h08, 6'h11};

    initial begin
        logic [5:0] rop, rfn;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b1; op_i[k] = '0; fn_i[k] = '0; o_i[k] = 1'b0; z_i[k] = 1'b0;
        end
        m_cause = 2'b00;
        #3;
        rst_n[0] = 1'b0;
        rst_n[1] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            do_reset(k);
            run(k, 6'h00, 6'h20, 1'b0, 1'b0, -1);   // add
            run(k, 6'h00, 6'h20, 1'b1, 1'b0, -1);   // add overflow
            run(k, 6'h3F, 6'h00, 1'b0, 1'b0, -1);   // invalid opcode
            run(k, 6'h23, 6'h00, 1'b0, 1'b0, -1);   // lw
            run(k, 6'h2B, 6'h00, 1'b0, 1'b0, -1);   // sw
            run(k, 6'h04, 6'h00, 1'b0, 1'b1, -1);   // beq taken
            run(k, 6'h05, 6'h00, 1'b0, 1'b1, -1);   // bne not taken
            run(k, 6'h04, 6'h00, 1'b0, 1'b0, -1);   // beq not taken
            run(k, 6'h02, 6'h00, 1'b0, 1'b0, -1);   // j
            run(k, 6'h00, 6'h08, 1'b0, 1'b0, -1);   // jr
            run(k, 6'h00, 6'h24, 1'b1, 1'b0, -1);   // and ignores O
            run(k, 6'h00, 6'h22, 1'b1, 1'b0, -1);   // sub overflow
            run(k, 6'h08, 6'h00, 1'b1, 1'b0, -1);   // addi overflow
            run(k, 6'h00, 6'h3A, 1'b0, 1'b0, -1);   // invalid funct
            run(k, 6'h23, 6'h00, 1'b0, 1'b0, (k == 0 ? 2 : 3) + 4);  // reset in 2nd LW_MEM cycle
            run(k, 6'h08, 6'h00, 1'b0, 1'b0, -1);   // addi after reset
            for (int n = 0; n < 60; n++) begin
                rop = op_tab[$urandom_range(8)];
                if (rop == 6'h3F) rop = 6'($urandom);
                rfn = fn_tab[$urandom_range(4)];
                if (rfn == 6'h11) rfn = 6'($urandom);
                run(k, rop, rfn, 1'($urandom), 1'($urandom), -1);
            end
            rst_n[k] = 1'b0;
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_ctrl_param.md
Name: multicycle_ctrl_param

Overview:
- Parametrised multicycle MIPS-subset control unit; successor to the fixed-timing controller.
- Drives the datapath muxes and write enables from a registered state plus a stall counter.
- Memory latency is a parameter, so fetch and load hold their address for a configurable number of cycles.
- Adds load/store, branch, jump and jr sequencing, plus a precise exception path: EPC capture, cause register, vector jump.

Parameters:
MEM_WAIT, 2, extra cycles the address is held before read data is valid (0..2^CNT_W-2)
CNT_W, 5, stall counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
OpCode  in  6  IR[31:26]
Funct  in  6  IR[5:0]
O  in  1  ALU overflow, combinational
Zero  in  1  ALU zero flag
IorD  out  3  000 PC, 001 ALUOut
MemWR  out  1  memory write
IRWrite  out  1  IR load
MDRWrite  out  1  MDR load
RegDst  out  2  00 rt, 01 rd
RegWR  out  1  register-file write
WriteA  out  1  A load
WriteB  out  1  B load
AluSrcA  out  2  00 PC, 01 A
AluSrcB  out  3  000 B, 001 const 4, 010 sext(imm), 011 sext(imm)<<2
AluOperation  out  3  001 add, 010 sub, 011 and
AluOutWrite  out  1  ALUOut load
MemToReg  out  3  000 ALUOut, 001 MDR
PCSource  out  3  000 ALU result, 001 ALUOut, 010 jump target, 011 A, 100 exception vector
PCWrite  out  1  PC load
EPCWrite  out  1  EPC load from ALU result
exc_cause  out  2  00 none, 01 invalid opcode, 10 overflow (registered)
state_o  out  6  current state, debug

Behaviour:
- Outputs are decoded combinationally from the registered state and counter. Any output not listed for a state is 0.
- Reset low: asynchronously state=RST, counter=0, exc_cause=00; all outputs 0. Reset mid-instruction aborts with no write enable asserted. First clk edge after release: RST->FETCH.
- FETCH, counter 0..MEM_WAIT: IorD=000, AluSrcA=00, AluSrcB=001, AluOperation=001, PCSource=000. Counter increments each cycle.
  - At counter==MEM_WAIT: IRWrite=1, PCWrite=1; counter<=0; ->DECODE. Total MEM_WAIT+1 cycles.
- DECODE (1 cycle): WriteA=1, WriteB=1, AluSrcA=00, AluSrcB=011, add, AluOutWrite=1. Dispatch:
  - OpCode 0x00 with Funct 0x20/0x22/0x24 ->R_EXEC; Funct 0x08 ->JR; any other Funct ->EXC cause 01.
  - 0x08 ->ADDI_EXEC; 0x23/0x2B ->MEM_ADDR; 0x04/0x05 ->BRANCH; 0x02 ->JUMP; any other OpCode ->EXC cause 01.
- R_EXEC: AluSrcA=01, AluSrcB=000, op per Funct (add/sub/and), AluOutWrite=1 ->R_WB.
- R_WB: ALU controls held at R_EXEC values.
  - add/sub with O=1: RegWR=0, ->EXC cause 10.
  - Otherwise RegDst=01, MemToReg=000, RegWR=1 ->FETCH. The and op ignores O.
- ADDI_EXEC: AluSrcA=01, AluSrcB=010, add, AluOutWrite=1 ->ADDI_WB.
- ADDI_WB: same as R_WB with RegDst=00.
- MEM_ADDR: AluSrcA=01, AluSrcB=010, add, AluOutWrite=1 ->LW_MEM (0x23) or SW_MEM (0x2B).
- LW_MEM: IorD=001 for MEM_WAIT+1 cycles; on the last cycle MDRWrite=1 ->LW_WB.
- LW_WB: RegDst=00, MemToReg=001, RegWR=1 ->FETCH.
- SW_MEM (1 cycle): IorD=001, MemWR=1 ->FETCH.
- BRANCH: AluSrcA=01, AluSrcB=000, sub, PCSource=001. PCWrite=Zero for 0x04, ~Zero for 0x05. ->FETCH.
- JUMP: PCSource=010, PCWrite=1 ->FETCH.
- JR: PCSource=011, PCWrite=1 ->FETCH.
- EXC, 2 cycles:
  - Entry edge: exc_cause<=cause.
  - c0: AluSrcA=00, AluSrcB=001, sub, EPCWrite=1 (EPC=PC-4).
  - c1: PCSource=100, PCWrite=1 ->FETCH.
  - exc_cause holds until the next exception or reset.
- Counter is cleared on every state change. An unknown state encoding recovers to FETCH.

Test Plan:
- MEM_WAIT=2, add (0x00/0x20), O=0: after reset release, FETCH lasts 3 cycles with IRWrite/PCWrite only on the 3rd -> DECODE, R_EXEC, R_WB with RegWR=1, RegDst=01. Total 6 cycles.
- add with O=1 at R_WB: RegWR stays 0 -> EXC; EPCWrite=1 one cycle, then PCWrite=1 with PCSource=100; exc_cause=10.
- OpCode 0x3F: DECODE -> EXC, exc_cause=01, no RegWR/MemWR asserted during the instruction.
- lw with MEM_WAIT=3: LW_MEM 4 cycles with IorD=001, MDRWrite only on the 4th; LW_WB MemToReg=001, RegWR=1. sw: one cycle MemWR=1.
- beq Zero=1 -> PCWrite=1, PCSource=001; bne Zero=1 -> PCWrite=0; j -> PCSource=010; jr -> PCSource=011.
- reset pulled low in the 2nd LW_MEM cycle: outputs 0 immediately, exc_cause=00; after release FETCH restarts with counter=0.
